// File: rtl/trade_pkg.sv
// Shared types for the trade limiter: halt causes and run/halt states.
// Imported by the limiter top level and its window timer.
package trade_pkg;

    localparam int CAUSE_W = 2;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_CH_LIMIT = 2'd1,
        CAUSE_TOTAL    = 2'd2
    } halt_cause_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/window_timer.sv
// Free-running wrap counter defining the rolling count window.
// tick_o marks the last cycle of every window.
module window_timer #(
    parameter int WIN_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int TW = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(WIN_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next phase: wrap to zero after the last cycle of the window
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Phase register, restarted by reset
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/trade_limiter.sv
// Per-channel rolling-window trade limiter with saturating lifetime total.
// Raises a sticky halt on a channel limit hit or on reaching MAX_TRADES.
module trade_limiter
    import trade_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int CNT_W      = 8,
    parameter  int MAX_TRADES = 100,
    parameter  int WIN_CYCLES = 1000,
    parameter  int DEF_LIMIT  = 0,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match_valid,
    input  logic [CH_W-1:0]  match_ch,
    input  logic             enable_count,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             halt_clear,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] trade_count,
    output logic             window_tick,
    output logic             halt_flag,
    output logic [1:0]       halt_cause,
    output logic [CH_W-1:0]  halt_ch
);

    localparam logic [CNT_W-1:0] SAT   = '1;
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_TRADES);
    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LIMIT);
    localparam logic [CH_W:0]    NCH_L = (CH_W + 1)'(N_CH);

    logic [CNT_W-1:0] win_q [N_CH];
    logic [CNT_W-1:0] win_d [N_CH];
    logic [CNT_W-1:0] lim_q [N_CH];
    logic [CNT_W-1:0] tc_q, tc_d;
    logic [CNT_W-1:0] rd_q;

    state_t           state_q, state_d;
    halt_cause_t      cause_q, cause_d;
    logic [CH_W-1:0]  hch_q, hch_d;

    logic             tick;
    logic             ch_ok, rd_ok;
    logic             counted, clr_ok;
    logic             trip_ch, trip_tot;
    logic [CNT_W-1:0] cur_win, new_win, new_tc, lim_sel;

    window_timer #(
        .WIN_CYCLES(WIN_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick_o(tick)
    );

    assign ch_ok   = ({1'b0, match_ch} < NCH_L);
    assign rd_ok   = ({1'b0, rd_ch} < NCH_L);
    assign counted = match_valid && enable_count
                  && (state_q == ST_RUN) && ch_ok;
    assign clr_ok  = (state_q == ST_HALT) && halt_clear
                  && (cause_q == CAUSE_CH_LIMIT);

    // Post-increment values; a tick-cycle trade starts the new window
    always_comb begin
        cur_win  = '0;
        lim_sel  = '0;
        if (ch_ok && !tick) cur_win = win_q[match_ch];
        if (ch_ok)          lim_sel = lim_q[match_ch];
        new_win  = (cur_win == SAT) ? SAT : cur_win + 1'b1;
        new_tc   = (tc_q == SAT) ? SAT : tc_q + 1'b1;
        trip_ch  = counted && (lim_sel != '0) && (new_win >= lim_sel);
        trip_tot = counted && !trip_ch && (new_tc >= MAX_L);
    end

    // Run/halt next state and latched halt reason
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hch_d   = hch_q;
        unique case (state_q)
            ST_RUN: begin
                if (trip_ch) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_CH_LIMIT;
                    hch_d   = match_ch;
                end else if (trip_tot) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_TOTAL;
                end
            end
            ST_HALT: begin
                if (clr_ok) begin
                    state_d = ST_RUN;
                    cause_d = CAUSE_NONE;
                end
            end
            default: ;
        endcase
    end

    // Window counts: clear on roll or on halt release, then add the trade
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            win_d[i] = (tick || clr_ok) ? '0 : win_q[i];
            if (counted && (match_ch == CH_W'(i))) win_d[i] = new_win;
        end
        tc_d = counted ? new_tc : tc_q;
    end

    // State, counters, limits and readback registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cause_q <= CAUSE_NONE;
            hch_q   <= '0;
            tc_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                win_q[i] <= '0;
                lim_q[i] <= DEF_L;
            end
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            hch_q   <= hch_d;
            tc_q    <= tc_d;
            rd_q    <= rd_ok ? win_q[rd_ch] : '0;
            for (int i = 0; i < N_CH; i++) begin
                win_q[i] <= win_d[i];
                if (cfg_we && (cfg_ch == CH_W'(i))) lim_q[i] <= cfg_limit;
            end
        end
    end

    assign rd_count    = rd_q;
    assign trade_count = tc_q;
    assign window_tick = tick;
    assign halt_flag   = (state_q == ST_HALT);
    assign halt_cause  = cause_q;
    assign halt_ch     = hch_q;

endmodule

// File: tb/tb_trade_limiter.sv
// Bench for trade_limiter: vector table, corner sequences, random run.
// A cycle-level reference model checks every output on every cycle.
module tb_trade_limiter;

    localparam int N_CH  = 3;
    localparam int CNT_W = 8;
    localparam int MAXT  = 20;
    localparam int WIN   = 10;
    localparam int DEFL  = 0;
    localparam int CH_W  = 2;

    logic             clk;
    logic             reset;
    logic             match_valid;
    logic [CH_W-1:0]  match_ch;
    logic             enable_count;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_limit;
    logic             halt_clear;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] trade_count;
    logic             window_tick;
    logic             halt_flag;
    logic [1:0]       halt_cause;
    logic [CH_W-1:0]  halt_ch;

    trade_limiter #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .MAX_TRADES(MAXT),
        .WIN_CYCLES(WIN),
        .DEF_LIMIT (DEFL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .enable_count(enable_count),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_limit   (cfg_limit),
        .halt_clear  (halt_clear),
        .rd_ch       (rd_ch),
        .rd_count    (rd_count),
        .trade_count (trade_count),
        .window_tick (window_tick),
        .halt_flag   (halt_flag),
        .halt_cause  (halt_cause),
        .halt_ch     (halt_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    int m_win [N_CH];
    int m_lim [N_CH];
    int m_total, m_phase, m_rd, m_halt, m_cause, m_hch;

    typedef struct {
        logic       mv;
        logic [1:0] ch;
        logic       en;
        logic       cwe;
        logic [1:0] cch;
        logic [7:0] clim;
        logic       hclr;
        int         e_tc;
        int         e_halt;
        int         e_cause;
        int         e_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input bit ok, input string det);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, det);
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        check(name, act == exp,
              $sformatf("got %0d expected %0d", act, exp));
    endtask

    task automatic model_edge();
        int old_rd, lchk, w;
        bit tk, cnt;
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                m_win[i] = 0;
                m_lim[i] = DEFL;
            end
            m_total = 0; m_phase = 0; m_rd = 0;
            m_halt = 0; m_cause = 0; m_hch = 0;
            return;
        end
        old_rd = (int'(rd_ch) < N_CH) ? m_win[rd_ch] : 0;
        tk = (m_phase == WIN - 1);
        cnt = match_valid && enable_count && (m_halt == 0)
           && (int'(match_ch) < N_CH);
        lchk = (int'(match_ch) < N_CH) ? m_lim[match_ch] : 0;
        if (cfg_we && int'(cfg_ch) < N_CH) m_lim[cfg_ch] = int'(cfg_limit);
        if (tk)
            for (int i = 0; i < N_CH; i++) m_win[i] = 0;
        if (m_halt == 1 && halt_clear && m_cause == 1) begin
            m_halt = 0;
            m_cause = 0;
            for (int i = 0; i < N_CH; i++) m_win[i] = 0;
        end
        if (cnt) begin
            w = m_win[match_ch] + 1;
            if (w > 255) w = 255;
            m_win[match_ch] = w;
            m_total = (m_total + 1 > 255) ? 255 : m_total + 1;
            if (lchk != 0 && w >= lchk) begin
                m_halt = 1; m_cause = 1; m_hch = int'(match_ch);
            end else if (m_total >= MAXT) begin
                m_halt = 1; m_cause = 2;
            end
        end
        m_rd = old_rd;
        m_phase = (m_phase + 1) % WIN;
    endtask

    // one clock: update model from current inputs, then compare after edge
    task automatic step();
        bit ok;
        model_edge();
        @(posedge clk);
        #1;
        ok = (int'(rd_count) == m_rd) && (int'(trade_count) == m_total)
          && (window_tick == (m_phase == WIN - 1))
          && (int'(halt_flag) == m_halt) && (int'(halt_cause) == m_cause)
          && (int'(halt_ch) == m_hch);
        check("model", ok, $sformatf(
            "rd=%0d/%0d tc=%0d/%0d tick=%0b/%0b halt=%0d/%0d cause=%0d/%0d ch=%0d/%0d",
            rd_count, m_rd, trade_count, m_total, window_tick,
            (m_phase == WIN - 1), halt_flag, m_halt, halt_cause, m_cause,
            halt_ch, m_hch));
    endtask

    task automatic set_in(input logic mv, input logic [1:0] ch,
                          input logic en, input logic cwe,
                          input logic [1:0] cch, input logic [7:0] clim,
                          input logic hclr);
        match_valid = mv; match_ch = ch; enable_count = en;
        cfg_we = cwe; cfg_ch = cch; cfg_limit = clim; halt_clear = hclr;
    endtask

    task automatic idle();
        set_in(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic trade(input logic [1:0] ch);
        set_in(1, ch, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        step();
        step();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        rd_ch = 0;
        idle();

        // gating, limit trip on ch2, clear/resume, tick-cycle trade
        vecs[0]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 1, 2, 3, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[4]  = '{1, 2, 1, 0, 0, 0, 0, 2, 0, 0, 1};
        vecs[5]  = '{1, 2, 1, 0, 0, 0, 0, 3, 1, 1, 2};
        vecs[6]  = '{1, 2, 1, 0, 0, 0, 0, 3, 1, 1, 3};
        vecs[7]  = '{0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 3};
        vecs[8]  = '{0, 0, 1, 0, 0, 0, 1, 3, 0, 0, 3};
        vecs[9]  = '{1, 2, 1, 0, 0, 0, 0, 4, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 4, 0, 0, 1};
        vecs[11] = '{0, 0, 1, 0, 0, 0, 0, 4, 0, 0, 1};

        do_reset();
        expect_eq("reset_tc", int'(trade_count), 0);
        expect_eq("reset_halt", int'(halt_flag), 0);
        expect_eq("reset_tick", int'(window_tick), 0);

        rd_ch = 2;
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].mv, vecs[i].ch, vecs[i].en, vecs[i].cwe,
                   vecs[i].cch, vecs[i].clim, vecs[i].hclr);
            step();
            check($sformatf("vec%0d", i),
                  int'(trade_count) == vecs[i].e_tc
                  && int'(halt_flag) == vecs[i].e_halt
                  && int'(halt_cause) == vecs[i].e_cause
                  && int'(rd_count) == vecs[i].e_rd,
                  $sformatf("tc=%0d halt=%0d cause=%0d rd=%0d want %0d %0d %0d %0d",
                            trade_count, halt_flag, halt_cause, rd_count,
                            vecs[i].e_tc, vecs[i].e_halt, vecs[i].e_cause,
                            vecs[i].e_rd));
            if (i == 5) expect_eq("trip_halt_ch", int'(halt_ch), 2);
        end

        // window roll: limit 2 on ch0, one trade per window incl. tick cycle
        do_reset();
        rd_ch = 0;
        set_in(0, 0, 1, 1, 0, 2, 0);
        step();
        trade(0);
        step();
        idle();
        for (int i = 0; i < 7; i++) step();
        expect_eq("roll_tick", int'(window_tick), 1);
        trade(0);
        step();
        expect_eq("roll_tick_drop", int'(window_tick), 0);
        idle();
        step();
        expect_eq("roll_rd", int'(rd_count), 1);
        expect_eq("roll_nohalt", int'(halt_flag), 0);

        // total halt, halt_clear ignored, reset restores
        do_reset();
        for (int k = 0; k < MAXT; k++) begin
            trade(2'(k % N_CH));
            step();
        end
        expect_eq("tot_tc", int'(trade_count), MAXT);
        expect_eq("tot_cause", int'(halt_cause), 2);
        set_in(0, 0, 1, 0, 0, 0, 1);
        step();
        expect_eq("tot_clr_ignored", int'(halt_flag), 1);
        trade(0);
        step();
        expect_eq("tot_no_count", int'(trade_count), MAXT);
        reset = 1;
        idle();
        step();
        expect_eq("tot_reset_tc", int'(trade_count), 0);
        expect_eq("tot_reset_cause", int'(halt_cause), 0);
        reset = 0;

        // config race on ch1
        do_reset();
        rd_ch = 1;
        set_in(0, 0, 1, 1, 1, 8, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            trade(1);
            step();
        end
        set_in(1, 1, 1, 1, 1, 2, 0);
        step();
        expect_eq("race_nohalt", int'(halt_flag), 0);
        trade(1);
        step();
        expect_eq("race_halt", int'(halt_cause), 1);
        expect_eq("race_halt_ch", int'(halt_ch), 1);
        idle();
        step();
        expect_eq("race_rd", int'(rd_count), 6);

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(299, 0) == 0);
            match_valid  = ($urandom_range(1, 0) == 1);
            match_ch     = 2'($urandom_range(3, 0));
            enable_count = ($urandom_range(9, 0) < 8);
            cfg_we       = ($urandom_range(19, 0) == 0);
            cfg_ch       = 2'($urandom_range(3, 0));
            cfg_limit    = 8'($urandom_range(10, 0));
            halt_clear   = ($urandom_range(9, 0) == 0);
            rd_ch        = 2'($urandom_range(3, 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
